// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows for 4/6/8-column Rijndael state.
// Ports: in_* handshake with mode bit, out_* head of 2-entry buffer, blk_cnt pops.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [32*NB-1:0]  out_data,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] fwd;
  logic [W-1:0] bwd;
  logic [W-1:0] xf;

  // Pure byte wiring: each output byte picks a fixed source byte.
  // The inverse index adds NB first so it never goes negative.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int FS  = (c + OFF) % NB;
      localparam int IS  = (c + NB - OFF) % NB;
      localparam int DST = W - 1 - 8 * (4 * c + r);
      localparam int SF  = W - 1 - 8 * (4 * FS + r);
      localparam int SI  = W - 1 - 8 * (4 * IS + r);
      assign fwd[DST -: 8] = in_data[SF -: 8];
      assign bwd[DST -: 8] = in_data[SI -: 8];
    end
  end

  assign xf = in_inv ? bwd : fwd;

  logic [W-1:0]     mem_q [2];
  logic [1:0]       minv_q;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign out_inv   = minv_q[rd_q];
  assign blk_cnt   = blk_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    blk_d = blk_q;
    if (push) wr_d = ~wr_q;
    if (pop) begin
      rd_d  = ~rd_q;
      blk_d = blk_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      blk_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      minv_q   <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      blk_q <= blk_d;
      if (push) begin
        mem_q[wr_q]  <= xf;
        minv_q[wr_q] <= in_inv;
      end
    end
  end

endmodule
